// File: rtl/riscv_ctrl_pkg.sv
// Shared decode encodings for the RV32 control-unit slice.
// Holds opcode constants, ALU_OP group codes, the IMM_SEL / WB_SEL /
// BRANCH_JUMP encodings, the pipe FSM state type and the control bundle
// that travels from the decoder into the register stage.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU_OP = {group, funct3}
    localparam logic [1:0] GRP_BASE    = 2'b00;
    localparam logic [1:0] GRP_ALT     = 2'b01;
    localparam logic [1:0] GRP_MULDIV  = 2'b10;
    localparam logic [1:0] GRP_SPECIAL = 2'b11;

    localparam logic [4:0] ALU_PASS_IMM = {GRP_SPECIAL, 3'b000};
    localparam logic [4:0] ALU_PC_IMM   = {GRP_SPECIAL, 3'b001};

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    localparam logic [3:0] BJ_NONE = 4'b0000;
    localparam logic [3:0] BJ_JAL  = 4'b0010;
    localparam logic [3:0] BJ_JALR = 4'b0011;

    // Conditional branches carry their compare type in the low bits.
    function automatic logic [3:0] bj_branch(input logic [2:0] funct3);
        return {1'b1, funct3};
    endfunction

    typedef enum logic {
        ST_RUN,
        ST_MULDIV_WAIT
    } state_e;

    typedef struct packed {
        logic [4:0] alu_op;
        imm_sel_e   imm_sel;
        logic       op1_sel;
        logic       op2_sel;
        wb_sel_e    wb_sel;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic [3:0] branch_jump;
        logic       write_enable;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Pure combinational RV32I(+M) instruction decoder.
// Ports:
//   instruction  in  32  instruction word to decode
//   ctrl         out     decoded control bundle (illegal encodings yield an
//                        all-zero bundle with only the illegal flag set)
//   is_muldiv    out  1  legal M-extension op (needs the multi-cycle slot)
module control_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [31:0] instruction,
    output ctrl_t       ctrl,
    output logic        is_muldiv
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       rd_nz;
    logic       legal;
    logic       unused_operand_bits;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign rd_nz  = |instruction[11:7];

    // Register specifiers are consumed by the register file, not here.
    assign unused_operand_bits = ^instruction[24:15];

    always_comb begin
        ctrl.alu_op       = '0;
        ctrl.imm_sel      = IMM_NONE;
        ctrl.op1_sel      = 1'b0;
        ctrl.op2_sel      = 1'b0;
        ctrl.wb_sel       = WB_ALU;
        ctrl.mem_read     = 1'b0;
        ctrl.mem_write    = 1'b0;
        ctrl.mem_size     = '0;
        ctrl.branch_jump  = BJ_NONE;
        ctrl.write_enable = 1'b0;
        ctrl.illegal      = 1'b0;
        is_muldiv         = 1'b0;
        legal             = 1'b1;

        case (opcode)
            OPC_LUI: begin
                ctrl.alu_op       = ALU_PASS_IMM;
                ctrl.imm_sel      = IMM_U;
                ctrl.op2_sel      = 1'b1;
                ctrl.write_enable = rd_nz;
            end
            OPC_AUIPC: begin
                ctrl.alu_op       = ALU_PC_IMM;
                ctrl.imm_sel      = IMM_U;
                ctrl.op1_sel      = 1'b1;
                ctrl.op2_sel      = 1'b1;
                ctrl.write_enable = rd_nz;
            end
            OPC_JAL: begin
                ctrl.alu_op       = ALU_PC_IMM;
                ctrl.imm_sel      = IMM_J;
                ctrl.op1_sel      = 1'b1;
                ctrl.op2_sel      = 1'b1;
                ctrl.wb_sel       = WB_PC4;
                ctrl.branch_jump  = BJ_JAL;
                ctrl.write_enable = rd_nz;
            end
            OPC_JALR: begin
                // Target is rs1+imm, so operand 1 stays on rs1.
                if (funct3 == 3'b000) begin
                    ctrl.alu_op       = ALU_PC_IMM;
                    ctrl.imm_sel      = IMM_I;
                    ctrl.op2_sel      = 1'b1;
                    ctrl.wb_sel       = WB_PC4;
                    ctrl.branch_jump  = BJ_JALR;
                    ctrl.write_enable = rd_nz;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings.
                if (funct3[2:1] != 2'b01) begin
                    ctrl.alu_op      = {GRP_BASE, funct3};
                    ctrl.imm_sel     = IMM_B;
                    ctrl.branch_jump = bj_branch(funct3);
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_LOAD: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    ctrl.imm_sel      = IMM_I;
                    ctrl.op2_sel      = 1'b1;
                    ctrl.wb_sel       = WB_MEM;
                    ctrl.mem_read     = 1'b1;
                    ctrl.mem_size     = funct3;
                    ctrl.write_enable = rd_nz;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_STORE: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
                    ctrl.imm_sel   = IMM_S;
                    ctrl.op2_sel   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.mem_size  = funct3;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                ctrl.alu_op       = {GRP_BASE, funct3};
                ctrl.imm_sel      = IMM_I;
                ctrl.op2_sel      = 1'b1;
                ctrl.write_enable = rd_nz;
                // Only the shift forms constrain funct7.
                if (funct3 == 3'b001) begin
                    if (funct7 != F7_BASE) legal = 1'b0;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) ctrl.alu_op = {GRP_ALT, funct3};
                    else if (funct7 != F7_BASE) legal = 1'b0;
                end
            end
            OPC_OP: begin
                ctrl.write_enable = rd_nz;
                if (funct7 == F7_BASE) begin
                    ctrl.alu_op = {GRP_BASE, funct3};
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    ctrl.alu_op = {GRP_ALT, funct3};
                end else if (funct7 == F7_MULDIV && M_EXT != 0) begin
                    ctrl.alu_op = {GRP_MULDIV, funct3};
                    is_muldiv   = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            is_muldiv    = 1'b0;
        end
    end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: registers the decoded controls of each accepted
// instruction and holds the decode slot for MULDIV_CYCLES total cycles when
// an M-extension op is accepted.
// Ports:
//   CLK, RESET           clock / synchronous active-high reset
//   INSTRUCTION,IN_VALID incoming instruction and its valid
//   IN_READY             instruction accepted this cycle when IN_VALID high
//   STALL                hold all registered outputs and the M-op counter
//   FLUSH                drop registered op and any M-op in flight
//   OUT_VALID..ILLEGAL   registered control outputs
//   MULDIV_BUSY          an M op currently holds the decode slot
module control_unit_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int M_EXT         = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    output logic [4:0]  ALU_OP,
    output logic [2:0]  IMM_SEL,
    output logic        OP1_SEL,
    output logic        OP2_SEL,
    output logic [1:0]  WB_SEL,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [2:0]  MEM_SIZE,
    output logic [3:0]  BRANCH_JUMP,
    output logic        WRITE_ENABLE,
    output logic        ILLEGAL,
    output logic        MULDIV_BUSY
);

    localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

    ctrl_t      dec_ctrl;
    logic       dec_muldiv;
    ctrl_t      ctrl_q;
    logic       valid_q;
    state_e     state;
    logic [3:0] count;
    logic       accept;

    control_decode #(
        .M_EXT(M_EXT)
    ) u_decode (
        .instruction(INSTRUCTION),
        .ctrl       (dec_ctrl),
        .is_muldiv  (dec_muldiv)
    );

    assign IN_READY = (state == ST_RUN) & ~STALL & ~RESET;
    // FLUSH does not gate IN_READY but still blocks the accept.
    assign accept   = IN_VALID & IN_READY & ~FLUSH;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_RUN;
            count   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (FLUSH) begin
            state   <= ST_RUN;
            count   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (!STALL) begin
            if (accept) begin
                valid_q <= 1'b1;
                ctrl_q  <= dec_ctrl;
                if (dec_muldiv) begin
                    state <= ST_MULDIV_WAIT;
                    count <= MULDIV_LOAD;
                end
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end

            // accept is impossible in MULDIV_WAIT, so no conflict with the load above.
            if (state == ST_MULDIV_WAIT) begin
                if (count == 4'd1) begin
                    state <= ST_RUN;
                    count <= '0;
                end else begin
                    count <= count - 4'd1;
                end
            end
        end
    end

    assign OUT_VALID    = valid_q;
    assign ALU_OP       = ctrl_q.alu_op;
    assign IMM_SEL      = ctrl_q.imm_sel;
    assign OP1_SEL      = ctrl_q.op1_sel;
    assign OP2_SEL      = ctrl_q.op2_sel;
    assign WB_SEL       = ctrl_q.wb_sel;
    assign MEM_READ     = ctrl_q.mem_read;
    assign MEM_WRITE    = ctrl_q.mem_write;
    assign MEM_SIZE     = ctrl_q.mem_size;
    assign BRANCH_JUMP  = ctrl_q.branch_jump;
    assign WRITE_ENABLE = ctrl_q.write_enable;
    assign ILLEGAL      = ctrl_q.illegal;
    assign MULDIV_BUSY  = (state == ST_MULDIV_WAIT);

endmodule

// File: tb/tb_control_unit_pipe.sv
// Bench for control_unit_pipe: one instance with M_EXT=1 and one with
// M_EXT=0 share the same stimulus; each is tracked by its own reference model.
module tb_control_unit_pipe;

    localparam int MC = 4;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_MUL  = 32'h027302B3;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h40315093;

    typedef struct packed {
        logic       valid;
        logic [4:0] alu;
        logic [2:0] imm;
        logic       op1;
        logic       op2;
        logic [1:0] wb;
        logic       mr;
        logic       mw;
        logic [2:0] msize;
        logic [3:0] bj;
        logic       we;
        logic       ill;
    } tb_ctrl_t;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        IN_VALID;
    logic        STALL;
    logic        FLUSH;

    logic rdy_m, ov_m, op1_m, op2_m, mr_m, mw_m, we_m, ill_m, busy_m;
    logic [4:0] alu_m;
    logic [2:0] imm_m, msz_m;
    logic [1:0] wb_m;
    logic [3:0] bj_m;
    logic rdy_n, ov_n, op1_n, op2_n, mr_n, mw_n, we_n, ill_n, busy_n;
    logic [4:0] alu_n;
    logic [2:0] imm_n, msz_n;
    logic [1:0] wb_n;
    logic [3:0] bj_n;

    tb_ctrl_t act_m, act_n;
    assign act_m = {ov_m, alu_m, imm_m, op1_m, op2_m, wb_m, mr_m, mw_m, msz_m, bj_m, we_m, ill_m};
    assign act_n = {ov_n, alu_n, imm_n, op1_n, op2_n, wb_n, mr_n, mw_n, msz_n, bj_n, we_n, ill_n};

    control_unit_pipe #(.M_EXT(1), .MULDIV_CYCLES(MC)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IN_VALID(IN_VALID),
        .IN_READY(rdy_m), .STALL(STALL), .FLUSH(FLUSH), .OUT_VALID(ov_m),
        .ALU_OP(alu_m), .IMM_SEL(imm_m), .OP1_SEL(op1_m), .OP2_SEL(op2_m),
        .WB_SEL(wb_m), .MEM_READ(mr_m), .MEM_WRITE(mw_m), .MEM_SIZE(msz_m),
        .BRANCH_JUMP(bj_m), .WRITE_ENABLE(we_m), .ILLEGAL(ill_m), .MULDIV_BUSY(busy_m)
    );

    control_unit_pipe #(.M_EXT(0), .MULDIV_CYCLES(MC)) dut_nom (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IN_VALID(IN_VALID),
        .IN_READY(rdy_n), .STALL(STALL), .FLUSH(FLUSH), .OUT_VALID(ov_n),
        .ALU_OP(alu_n), .IMM_SEL(imm_n), .OP1_SEL(op1_n), .OP2_SEL(op2_n),
        .WB_SEL(wb_n), .MEM_READ(mr_n), .MEM_WRITE(mw_n), .MEM_SIZE(msz_n),
        .BRANCH_JUMP(bj_n), .WRITE_ENABLE(we_n), .ILLEGAL(ill_n), .MULDIV_BUSY(busy_n)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference decode: what each instruction class must produce.
    function automatic tb_ctrl_t ref_decode(input logic [31:0] i, input bit m_ext);
        tb_ctrl_t   c;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok;
        bit         wr;
        c  = '0;
        c.valid = 1'b1;
        f3 = i[14:12];
        f7 = i[31:25];
        ok = 1'b1;
        wr = (i[11:7] != 5'd0);
        case (i[6:0])
            7'h37: begin c.alu = 5'b11000; c.imm = 3'd4; c.op2 = 1; c.we = wr; end
            7'h17: begin c.alu = 5'b11001; c.imm = 3'd4; c.op1 = 1; c.op2 = 1; c.we = wr; end
            7'h6F: begin c.alu = 5'b11001; c.imm = 3'd5; c.op1 = 1; c.op2 = 1; c.wb = 2'd2;
                         c.bj = 4'b0010; c.we = wr; end
            7'h67: begin ok = (f3 == 3'd0); c.alu = 5'b11001; c.imm = 3'd1; c.op2 = 1;
                         c.wb = 2'd2; c.bj = 4'b0011; c.we = wr; end
            7'h63: begin ok = !(f3 == 3'd2 || f3 == 3'd3); c.alu = {2'b00, f3}; c.imm = 3'd3;
                         c.bj = {1'b1, f3}; end
            7'h03: begin ok = (f3 != 3'd3 && f3 < 3'd6); c.imm = 3'd1; c.op2 = 1; c.wb = 2'd1;
                         c.mr = 1; c.msize = f3; c.we = wr; end
            7'h23: begin ok = (f3 < 3'd3); c.imm = 3'd2; c.op2 = 1; c.mw = 1; c.msize = f3; end
            7'h13: begin
                c.imm = 3'd1; c.op2 = 1; c.we = wr; c.alu = {2'b00, f3};
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                else if (f3 == 3'd5) begin
                    ok = (f7 == 7'h00 || f7 == 7'h20);
                    if (f7 == 7'h20) c.alu = {2'b01, f3};
                end
            end
            7'h33: begin
                c.we = wr;
                if (f7 == 7'h00) c.alu = {2'b00, f3};
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) c.alu = {2'b01, f3};
                else if (f7 == 7'h01 && m_ext) c.alu = {2'b10, f3};
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            c = '0;
            c.valid = 1'b1;
            c.ill = 1'b1;
        end
        return c;
    endfunction

    function automatic bit is_mop(input logic [31:0] i, input bit m_ext);
        return m_ext && i[6:0] == 7'h33 && i[31:25] == 7'h01;
    endfunction

    // Model: busy = cycles the slot is still held after an accepted M op.
    tb_ctrl_t exp_m, exp_n;
    int       hold_m, hold_n;
    bit       started = 1'b0;

    task automatic model_step(input bit m_ext, inout tb_ctrl_t e, inout int hold);
        if (RESET || FLUSH) begin
            e = '0;
            hold = 0;
        end else if (!STALL) begin
            if (hold > 0) begin
                hold--;
                e = '0;
            end else if (IN_VALID) begin
                e = ref_decode(INSTRUCTION, m_ext);
                if (is_mop(INSTRUCTION, m_ext)) hold = MC - 1;
            end else begin
                e = '0;
            end
        end
    endtask

    always @(posedge CLK) begin
        if (RESET) started = 1'b1;
        model_step(1'b1, exp_m, hold_m);
        model_step(1'b0, exp_n, hold_n);
    end

    task automatic cmp_inst(input string tag, input tb_ctrl_t a, input logic rdy, input logic bsy,
                            input tb_ctrl_t e, input int hold);
        chk({tag, " OUT_VALID"},    a.valid, e.valid);
        chk({tag, " WRITE_ENABLE"}, a.we, e.we);
        chk({tag, " MEM_READ"},     a.mr, e.mr);
        chk({tag, " MEM_WRITE"},    a.mw, e.mw);
        chk({tag, " BRANCH_JUMP"},  a.bj, e.bj);
        chk({tag, " ILLEGAL"},      a.ill, e.ill);
        chk({tag, " IN_READY"},     rdy, (hold == 0 && !STALL && !RESET));
        chk({tag, " MULDIV_BUSY"},  bsy, (hold > 0));
        if (e.valid) begin
            chk({tag, " ALU_OP"},   a.alu, e.alu);
            chk({tag, " IMM_SEL"},  a.imm, e.imm);
            chk({tag, " OP1_SEL"},  a.op1, e.op1);
            chk({tag, " OP2_SEL"},  a.op2, e.op2);
            chk({tag, " WB_SEL"},   a.wb, e.wb);
            chk({tag, " MEM_SIZE"}, a.msize, e.msize);
        end
    endtask

    always @(negedge CLK) begin
        if (started) begin
            cmp_inst("m1", act_m, rdy_m, busy_m, exp_m, hold_m);
            cmp_inst("m0", act_n, rdy_n, busy_n, exp_n, hold_n);
        end
    end

    // Inputs change just after a falling edge; the caller resumes on the next falling edge.
    task automatic drive(input logic [31:0] instr, input logic v, input logic st,
                         input logic fl, input logic rs);
        #1;
        INSTRUCTION = instr;
        IN_VALID    = v;
        STALL       = st;
        FLUSH       = fl;
        RESET       = rs;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic mul_window(input int n_stall, output int n_busy, output int n_low,
                              output int n_valid);
        n_busy = 0; n_low = 0; n_valid = 0;
        drive(I_MUL, 1, 0, 0, 0);
        n_busy += int'(busy_m); n_low += int'(!rdy_m); n_valid += int'(ov_m);
        for (int k = 0; k < n_stall; k++) begin
            drive('0, 0, 1, 0, 0);
            n_busy += int'(busy_m); n_low += int'(!rdy_m); n_valid += int'(ov_m);
        end
        for (int k = 0; k < 5; k++) begin
            drive('0, 0, 0, 0, 0);
            n_busy += int'(busy_m); n_low += int'(!rdy_m); n_valid += int'(ov_m);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] sweep [16] = '{
        32'h00001117, 32'h000280E7, 32'h00500093, 32'h0000000F,
        32'h00000073, 32'h00208033, 32'h042081B3, 32'h0020A463,
        32'h027352B3, 32'h40311093, 32'h0000B183, 32'h000290E7,
        32'h0020B223, I_SW,         I_JAL,        32'h40205233
    };

    initial begin
        tb_ctrl_t t;
        int nb, nl, nv;

        INSTRUCTION = '0; IN_VALID = 0; STALL = 0; FLUSH = 0; RESET = 1;

        t = ref_decode(I_MUL, 1'b0);
        chk("model mul_noM ILLEGAL", t.ill, 1);
        chk("model mul_noM WE", t.we, 0);
        t = ref_decode(I_SW, 1'b1);
        chk("model sw MEM_WRITE/SIZE/WE", {t.mw, t.msize, t.we}, {1'b1, 3'd2, 1'b0});
        t = ref_decode(I_JAL, 1'b1);
        chk("model jal BJ/WB", {t.bj, t.wb}, {4'b0010, 2'd2});

        // Reset state
        drive('0, 0, 0, 0, 1);
        drive('0, 0, 0, 0, 1);
        chk("reset outputs m1", act_m, '0);
        chk("reset outputs m0", act_n, '0);
        chk("reset MULDIV_BUSY", busy_m, 0);
        chk("reset IN_READY", rdy_m, 0);
        drive('0, 0, 0, 0, 0);
        chk("post-reset IN_READY", rdy_m, 1);

        // add x3,x1,x2
        drive(I_ADD, 1, 0, 0, 0);
        chk("add OUT_VALID", ov_m, 1);
        chk("add ALU_OP", alu_m, 5'b00000);
        chk("add OP2_SEL", op2_m, 0);
        chk("add WRITE_ENABLE", we_m, 1);
        chk("add WB_SEL", wb_m, 0);
        drive('0, 0, 0, 0, 0);
        chk("idle OUT_VALID", ov_m, 0);

        drive(I_SUB, 1, 0, 0, 0);
        chk("sub ALU_OP", alu_m, 5'b01000);
        drive(I_SRAI, 1, 0, 0, 0);
        chk("srai ALU_OP", alu_m, 5'b01101);
        chk("srai IMM_SEL/OP2_SEL", {imm_m, op2_m}, {3'd1, 1'b1});
        drive(I_LUI, 1, 0, 0, 0);
        chk("lui ALU_OP", alu_m, 5'b11000);
        chk("lui IMM_SEL", imm_m, 3'd4);

        // mul: single pulse, slot held 3 further cycles
        drive(I_MUL, 1, 0, 0, 0);
        chk("mul ALU_OP", alu_m, 5'b10000);
        chk("mul_noM ILLEGAL", ill_n, 1);
        chk("mul_noM WRITE_ENABLE", we_n, 0);
        chk("mul_noM IN_READY", rdy_n, 1);
        repeat (4) drive('0, 0, 0, 0, 0);
        mul_window(0, nb, nl, nv);
        chk("mul busy cycles", nb, 3);
        chk("mul ready-low cycles", nl, 3);
        chk("mul OUT_VALID pulses", nv, 1);

        // Counter frozen by STALL during MULDIV_WAIT
        mul_window(2, nb, nl, nv);
        chk("mul+stall busy cycles", nb, 5);
        chk("mul+stall ready-low cycles", nl, 5);
        chk("mul+stall OUT_VALID cycles", nv, 3);

        // beq held under STALL
        drive(I_BEQ, 1, 0, 0, 0);
        chk("beq BRANCH_JUMP", bj_m, 4'b1000);
        for (int k = 0; k < 2; k++) begin
            drive('0, 0, 1, 0, 0);
            chk("beq stall BRANCH_JUMP", bj_m, 4'b1000);
            chk("beq stall IMM_SEL", imm_m, 3'd3);
            chk("beq stall WRITE_ENABLE", we_m, 0);
            chk("beq stall OUT_VALID", ov_m, 1);
        end
        drive('0, 0, 0, 0, 0);
        chk("beq release OUT_VALID", ov_m, 0);

        // FLUSH+STALL with counter at 2
        drive(I_MUL, 1, 0, 0, 0);
        drive('0, 0, 0, 0, 0);
        chk("flush pre MULDIV_BUSY", busy_m, 1);
        drive('0, 0, 1, 1, 0);
        chk("flush OUT_VALID", ov_m, 0);
        chk("flush MULDIV_BUSY", busy_m, 0);
        #1;
        STALL = 0;
        FLUSH = 0;
        #1;
        chk("flush IN_READY", rdy_m, 1);

        // Instruction presented with FLUSH is dropped
        drive(I_ADD, 1, 0, 1, 0);
        chk("flush-drop OUT_VALID", ov_m, 0);
        chk("flush-drop WRITE_ENABLE", we_m, 0);

        // RESET mid-MULDIV_WAIT, then lw
        drive(I_MUL, 1, 0, 0, 0);
        drive('0, 0, 0, 0, 0);
        drive('0, 0, 1, 1, 1);
        chk("midreset outputs", act_m, '0);
        chk("midreset MULDIV_BUSY", busy_m, 0);
        drive(I_LW, 1, 0, 0, 0);
        chk("lw OUT_VALID", ov_m, 1);
        chk("lw MEM_READ", mr_m, 1);
        chk("lw WB_SEL", wb_m, 2'd1);
        chk("lw MEM_SIZE", msz_m, 3'b010);

        // Sweep of further encodings, checked by the per-cycle model compare
        for (int k = 0; k < 16; k++) begin
            drive(sweep[k], 1, 0, 0, 0);
            repeat (4) drive('0, 0, 0, 0, 0);
        end

        drive('0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
